// File: rtl/led_blinker_pkg.sv
// ============================================================================
// led_blinker_pkg : shared types for the multi-channel LED blinker
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package led_blinker_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BURST = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_ON    = 2'd1,
      ST_BLINK = 2'd2,
      ST_BURST = 2'd3
   } ch_state_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/led_blinker_if.sv
// ============================================================================
// led_blinker_if : valid/ready configuration port (cfg_duty with LED_BLINKER_PWM_EN)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_blinker_if
   import led_blinker_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int PERIOD_W = 16,
   parameter int COUNT_W  = 8,
   parameter int PWM_W    = 4
) ();

   localparam int CH_W = ch_width(NUM_CH);

   logic                cfg_valid;
   logic                cfg_ready;
   logic [CH_W-1:0]     cfg_ch;
   mode_t               cfg_mode;
   logic [PERIOD_W-1:0] cfg_half_period;
   logic [COUNT_W-1:0]  cfg_count;
`ifdef LED_BLINKER_PWM_EN
   logic [PWM_W-1:0]    cfg_duty;

   modport master (output cfg_valid, cfg_ch, cfg_mode, cfg_half_period, cfg_count, cfg_duty,
                   input  cfg_ready);
   modport slave  (input  cfg_valid, cfg_ch, cfg_mode, cfg_half_period, cfg_count, cfg_duty,
                   output cfg_ready);
`else
   modport master (output cfg_valid, cfg_ch, cfg_mode, cfg_half_period, cfg_count,
                   input  cfg_ready);
   modport slave  (input  cfg_valid, cfg_ch, cfg_mode, cfg_half_period, cfg_count,
                   output cfg_ready);
`endif

endinterface

`default_nettype wire

// File: rtl/led_blinker_ch.sv
// ============================================================================
// led_blinker_ch : one LED channel (off/on/blink/burst), duty gating with LED_BLINKER_PWM_EN
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module led_blinker_ch
   import led_blinker_pkg::*;
#(
   parameter int PERIOD_W = 16,
   parameter int COUNT_W  = 8
`ifdef LED_BLINKER_PWM_EN
   ,
   parameter int PWM_W    = 4
`endif
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   input  wire logic                i_load,
   input  wire logic                i_tick,
   input  wire mode_t               i_mode,
   input  wire logic [PERIOD_W-1:0] i_half_period,
   input  wire logic [COUNT_W-1:0]  i_count,
`ifdef LED_BLINKER_PWM_EN
   input  wire logic [PWM_W-1:0]    i_duty,
   input  wire logic [PWM_W-1:0]    i_pwm_cnt,
`endif
   output logic                     o_led,
   output logic                     o_busy,
   output logic                     o_done
);

   ch_state_t           r_state,     w_state_nxt;
   logic [PERIOD_W-1:0] r_phase,     w_phase_nxt;
   logic [PERIOD_W-1:0] r_hp,        w_hp_nxt;
   logic [COUNT_W-1:0]  r_remaining, w_remaining_nxt;
   logic                r_lit,       w_lit_nxt;
   logic                r_done,      w_done_nxt;
   logic                w_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_OFF;
         r_phase     <= '0;
         r_hp        <= PERIOD_W'(1);
         r_remaining <= '0;
         r_lit       <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_phase     <= w_phase_nxt;
         r_hp        <= w_hp_nxt;
         r_remaining <= w_remaining_nxt;
         r_lit       <= w_lit_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign w_wrap = (r_phase == (r_hp - PERIOD_W'(1)));

   // A load takes priority over a coincident tick, so the tick is dropped here.
   always_comb begin
      w_state_nxt     = r_state;
      w_phase_nxt     = r_phase;
      w_hp_nxt        = r_hp;
      w_remaining_nxt = r_remaining;
      w_lit_nxt       = r_lit;
      w_done_nxt      = 1'b0;
      if (i_load) begin
         w_phase_nxt     = '0;
         w_hp_nxt        = (i_half_period == '0) ? PERIOD_W'(1) : i_half_period;
         w_remaining_nxt = i_count;
         case (i_mode)
            MODE_OFF: begin
               w_state_nxt = ST_OFF;
               w_lit_nxt   = 1'b0;
            end
            MODE_ON: begin
               w_state_nxt = ST_ON;
               w_lit_nxt   = 1'b1;
            end
            MODE_BLINK: begin
               w_state_nxt = ST_BLINK;
               w_lit_nxt   = 1'b1;
            end
            default: begin
               if (i_count == '0) begin
                  w_state_nxt = ST_OFF;
                  w_lit_nxt   = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_BURST;
                  w_lit_nxt   = 1'b1;
               end
            end
         endcase
      end else if (i_tick && (r_state == ST_BLINK || r_state == ST_BURST)) begin
         if (w_wrap) begin
            w_phase_nxt = '0;
            w_lit_nxt   = ~r_lit;
            if (r_state == ST_BURST && r_lit) begin
               w_remaining_nxt = r_remaining - COUNT_W'(1);
               if (r_remaining == COUNT_W'(1)) begin
                  w_state_nxt = ST_OFF;
                  w_lit_nxt   = 1'b0;
                  w_done_nxt  = 1'b1;
               end
            end
         end else begin
            w_phase_nxt = r_phase + PERIOD_W'(1);
         end
      end
   end

   assign o_busy = (r_state == ST_BURST);
   assign o_done = r_done;

`ifdef LED_BLINKER_PWM_EN
   logic [PWM_W-1:0] r_duty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_duty <= '0;
      else if (i_load)
         r_duty <= i_duty;
   end

   assign o_led = r_lit && ((r_duty == '1) || (i_pwm_cnt < r_duty));
`else
   assign o_led = r_lit;
`endif

endmodule

`default_nettype wire

// File: rtl/led_blinker_array.sv
// ============================================================================
// led_blinker_array : NUM_CH LED blinkers sharing one prescaler tick
// Optional PWM dimming via LED_BLINKER_PWM_EN.  Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module led_blinker_array
   import led_blinker_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int TICK_HZ  = 1_000,
   parameter int NUM_CH   = 4,
   parameter int PERIOD_W = 16,
   parameter int COUNT_W  = 8,
   parameter int PWM_W    = 4
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   led_blinker_if.slave            cfg,
   output logic [NUM_CH-1:0]       led,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       done
);

   localparam int                 c_DIV     = CLK_HZ / TICK_HZ;
   localparam int                 c_PRE_W   = (c_DIV > 1) ? $clog2(c_DIV) : 1;
   localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(c_DIV - 1);
   localparam int                 c_CH_W    = ch_width(NUM_CH);

   if (c_DIV < 2 || NUM_CH < 1 || PWM_W < 1) begin : g_bad_cfg
      $error("led_blinker_array: unsupported parameter set");
   end

   logic [c_PRE_W-1:0] r_presc;
   logic               r_ready;
   logic               w_tick;
   logic               w_xfer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b1;
         r_presc <= w_tick ? '0 : r_presc + c_PRE_W'(1);
      end
   end

   assign w_tick        = (r_presc == c_PRE_MAX);
   assign cfg.cfg_ready = r_ready;
   assign w_xfer        = cfg.cfg_valid && r_ready;

`ifdef LED_BLINKER_PWM_EN
   logic [PWM_W-1:0] r_pwm_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_pwm_cnt <= '0;
      else
         r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
   end
`endif

   // Out-of-range channel numbers match no instance, so the transfer is dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic w_load;
      assign w_load = w_xfer && (cfg.cfg_ch == c_CH_W'(i));

      led_blinker_ch #(
         .PERIOD_W      (PERIOD_W),
         .COUNT_W       (COUNT_W)
`ifdef LED_BLINKER_PWM_EN
         ,
         .PWM_W         (PWM_W)
`endif
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .i_load        (w_load),
         .i_tick        (w_tick),
         .i_mode        (cfg.cfg_mode),
         .i_half_period (cfg.cfg_half_period),
         .i_count       (cfg.cfg_count),
`ifdef LED_BLINKER_PWM_EN
         .i_duty        (cfg.cfg_duty),
         .i_pwm_cnt     (r_pwm_cnt),
`endif
         .o_led         (led[i]),
         .o_busy        (busy[i]),
         .o_done        (done[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_led_blinker_array.sv
// ============================================================================
// tb_led_blinker_array : scoreboard bench for led_blinker_array (DIV = 10)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_blinker_array;
   import led_blinker_pkg::*;

   localparam int CLK_HZ   = 1000;
   localparam int TICK_HZ  = 100;
   localparam int DIV      = CLK_HZ / TICK_HZ;
   localparam int NUM_CH   = 5;
   localparam int PERIOD_W = 16;
   localparam int COUNT_W  = 8;
   localparam int PWM_W    = 4;
   localparam int CH_W     = 3;
   localparam int PWM_MOD  = 2 ** PWM_W;
   localparam int VW       = 3 * NUM_CH;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [NUM_CH-1:0] led, busy, done;

   led_blinker_if #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W), .PWM_W(PWM_W)) cfg_if ();

   led_blinker_array #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_CH(NUM_CH),
      .PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W), .PWM_W(PWM_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg(cfg_if), .led(led), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Edges since reset release; the prescaler ticks on every edge that is a multiple of DIV.
   int cyc;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   int m_mode [NUM_CH];
   int m_nx   [NUM_CH];
   int m_hp   [NUM_CH];
   int m_cnt  [NUM_CH];
   int m_duty [NUM_CH];

   logic [VW-1:0] sb_q [$];
   logic [VW-1:0] exp_v;

   function automatic logic [2:0] exp_ch(input int c, input int n);
      int t, lim;
      logic l, b, d;
      l = 1'b0; b = 1'b0; d = 1'b0;
      t = n / DIV - m_nx[c] / DIV;
      case (m_mode[c])
         1: l = 1'b1;
         2: l = ((t / m_hp[c]) % 2) == 0;
         3: begin
            if (m_cnt[c] == 0) begin
               d = (n == m_nx[c]);
            end else begin
               lim = (2 * m_cnt[c] - 1) * m_hp[c];
               if (t < lim) begin
                  l = ((t / m_hp[c]) % 2) == 0;
                  b = 1'b1;
               end else begin
                  d = (t == lim) && (n % DIV == 0);
               end
            end
         end
         default: ;
      endcase
`ifdef LED_BLINKER_PWM_EN
      if (!(m_duty[c] == PWM_MOD - 1 || (n % PWM_MOD) < m_duty[c])) l = 1'b0;
`endif
      return {l, b, d};
   endfunction

   function automatic logic [VW-1:0] exp_all(input int n);
      logic [NUM_CH-1:0] el, eb, ed;
      logic [2:0] v;
      el = '0; eb = '0; ed = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         v = exp_ch(c, n);
         el[c] = v[2]; eb[c] = v[1]; ed[c] = v[0];
      end
      return {el, eb, ed};
   endfunction

   task automatic push_expect();
      sb_q.push_back(exp_all(cyc + 1));
   endtask

   task automatic model_clear();
      for (int c = 0; c < NUM_CH; c++) begin
         m_mode[c] = 0; m_nx[c] = 0; m_hp[c] = 1; m_cnt[c] = 0; m_duty[c] = PWM_MOD - 1;
      end
      sb_q.delete();
   endtask

   // Called at a negedge; the transfer happens on the following posedge.
   task automatic drive_cfg(input int ch, input int mode, input int hp, input int cnt, input int duty);
      cfg_if.cfg_valid       = 1'b1;
      cfg_if.cfg_ch          = CH_W'(ch);
      cfg_if.cfg_mode        = mode_t'(mode[1:0]);
      cfg_if.cfg_half_period = PERIOD_W'(hp);
      cfg_if.cfg_count       = COUNT_W'(cnt);
`ifdef LED_BLINKER_PWM_EN
      cfg_if.cfg_duty        = PWM_W'(duty);
`endif
      if (ch < NUM_CH) begin
         m_mode[ch] = mode;
         m_nx[ch]   = cyc + 1;
         m_hp[ch]   = (hp == 0) ? 1 : hp;
         m_cnt[ch]  = cnt;
         m_duty[ch] = duty;
      end
   endtask

   task automatic test_reset();
      repeat (5) @(negedge clk);
      n_chk += 4;
      if (led !== '0)  begin n_fail++; $display("FAIL reset_led got=%b exp=0", led); end
      if (busy !== '0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      if (done !== '0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", cfg_if.cfg_ready); end
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%b exp=1", cfg_if.cfg_ready); end
   endtask

   task automatic test_blink();
      drive_cfg(1, 2, 3, 0, PWM_MOD - 1);
      repeat (100) begin
         push_expect();
         @(negedge clk);
         cfg_if.cfg_valid = 1'b0;
         exp_v = sb_q.pop_front();
         n_chk++;
         if ({led, busy, done} !== exp_v) begin
            n_fail++; $display("FAIL blink cyc=%0d got=%h exp=%h", cyc, {led, busy, done}, exp_v);
         end
      end
   endtask

   task automatic test_burst();
      int dn = 0;
      drive_cfg(0, 3, 1, 3, PWM_MOD - 1);
      repeat (80) begin
         push_expect();
         @(negedge clk);
         cfg_if.cfg_valid = 1'b0;
         exp_v = sb_q.pop_front();
         if (done[0]) dn++;
         n_chk++;
         if ({led, busy, done} !== exp_v) begin
            n_fail++; $display("FAIL burst cyc=%0d got=%h exp=%h", cyc, {led, busy, done}, exp_v);
         end
      end
      n_chk++;
      if (dn !== 1) begin n_fail++; $display("FAIL burst_done_count got=%0d exp=1", dn); end
   endtask

   task automatic test_abort();
      int dn = 0;
      drive_cfg(0, 3, 1, 5, PWM_MOD - 1);
      for (int k = 0; k < 110; k++) begin
         if (k == 45) drive_cfg(0, 0, 1, 0, PWM_MOD - 1);
         push_expect();
         @(negedge clk);
         cfg_if.cfg_valid = 1'b0;
         exp_v = sb_q.pop_front();
         if (done[0]) dn++;
         n_chk++;
         if ({led, busy, done} !== exp_v) begin
            n_fail++; $display("FAIL abort cyc=%0d got=%h exp=%h", cyc, {led, busy, done}, exp_v);
         end
      end
      n_chk++;
      if (dn !== 0) begin n_fail++; $display("FAIL abort_done_count got=%0d exp=0", dn); end
   endtask

   task automatic test_burst_zero();
      int dn = 0;
      int bz = 0;
      drive_cfg(4, 3, 2, 0, PWM_MOD - 1);
      repeat (20) begin
         push_expect();
         @(negedge clk);
         cfg_if.cfg_valid = 1'b0;
         exp_v = sb_q.pop_front();
         if (done[4]) dn++;
         if (busy[4]) bz++;
         n_chk++;
         if ({led, busy, done} !== exp_v) begin
            n_fail++; $display("FAIL burst_zero cyc=%0d got=%h exp=%h", cyc, {led, busy, done}, exp_v);
         end
      end
      n_chk += 2;
      if (dn !== 1) begin n_fail++; $display("FAIL burst_zero_done got=%0d exp=1", dn); end
      if (bz !== 0) begin n_fail++; $display("FAIL burst_zero_busy got=%0d exp=0", bz); end
   endtask

   task automatic test_bad_ch();
      drive_cfg(NUM_CH, 1, 1, 0, PWM_MOD - 1);
      repeat (20) begin
         push_expect();
         @(negedge clk);
         cfg_if.cfg_valid = 1'b0;
         exp_v = sb_q.pop_front();
         n_chk++;
         if ({led, busy, done} !== exp_v) begin
            n_fail++; $display("FAIL bad_ch cyc=%0d got=%h exp=%h", cyc, {led, busy, done}, exp_v);
         end
      end
   endtask

   task automatic test_collision();
      drive_cfg(3, 2, 1, 0, PWM_MOD - 1);
      for (int k = 0; k < 90; k++) begin
         // Once ch3 is running, aim the ch2 transfer exactly at a tick edge.
         if (k >= 25 && k < 36 && cyc % DIV == DIV - 1 && m_mode[2] == 0) drive_cfg(2, 2, 2, 0, PWM_MOD - 1);
         push_expect();
         @(negedge clk);
         cfg_if.cfg_valid = 1'b0;
         exp_v = sb_q.pop_front();
         n_chk++;
         if ({led, busy, done} !== exp_v) begin
            n_fail++; $display("FAIL collision cyc=%0d got=%h exp=%h", cyc, {led, busy, done}, exp_v);
         end
      end
      n_chk++;
      if (m_nx[2] % DIV !== 0) begin n_fail++; $display("FAIL collision_align got=%0d exp=0", m_nx[2] % DIV); end
   endtask

`ifdef LED_BLINKER_PWM_EN
   task automatic test_pwm();
      int hi;
      int duties [3] = '{4, 15, 0};
      int want   [3] = '{8, 32, 0};
      for (int d = 0; d < 3; d++) begin
         hi = 0;
         drive_cfg(0, 1, 1, 0, duties[d]);
         push_expect();
         @(negedge clk);
         cfg_if.cfg_valid = 1'b0;
         exp_v = sb_q.pop_front();
         n_chk++;
         if ({led, busy, done} !== exp_v) begin
            n_fail++; $display("FAIL pwm_load cyc=%0d got=%h exp=%h", cyc, {led, busy, done}, exp_v);
         end
         repeat (32) begin
            push_expect();
            @(negedge clk);
            exp_v = sb_q.pop_front();
            if (led[0]) hi++;
            n_chk++;
            if ({led, busy, done} !== exp_v) begin
               n_fail++; $display("FAIL pwm cyc=%0d got=%h exp=%h", cyc, {led, busy, done}, exp_v);
            end
         end
         n_chk++;
         if (hi !== want[d]) begin n_fail++; $display("FAIL pwm_high_count duty=%0d got=%0d exp=%0d", duties[d], hi, want[d]); end
      end
   endtask
`endif

   task automatic test_async_reset();
      drive_cfg(0, 3, 2, 4, PWM_MOD - 1);
      repeat (25) begin
         push_expect();
         @(negedge clk);
         cfg_if.cfg_valid = 1'b0;
         exp_v = sb_q.pop_front();
         n_chk++;
         if ({led, busy, done} !== exp_v) begin
            n_fail++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, {led, busy, done}, exp_v);
         end
      end
      n_chk++;
      if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy got=%b exp=1", busy[0]); end
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      n_chk += 4;
      if (led !== '0)  begin n_fail++; $display("FAIL async_led got=%b exp=0", led); end
      if (busy !== '0) begin n_fail++; $display("FAIL async_busy got=%b exp=0", busy); end
      if (done !== '0) begin n_fail++; $display("FAIL async_done got=%b exp=0", done); end
      if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL async_ready got=%b exp=0", cfg_if.cfg_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) begin
         push_expect();
         @(negedge clk);
         exp_v = sb_q.pop_front();
         n_chk++;
         if ({led, busy, done} !== exp_v) begin
            n_fail++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, {led, busy, done}, exp_v);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_if.cfg_valid       = 1'b0;
      cfg_if.cfg_ch          = '0;
      cfg_if.cfg_mode        = MODE_OFF;
      cfg_if.cfg_half_period = '0;
      cfg_if.cfg_count       = '0;
`ifdef LED_BLINKER_PWM_EN
      cfg_if.cfg_duty        = '0;
`endif
      model_clear();
      test_reset();
      test_blink();
      test_burst();
      test_abort();
      test_burst_zero();
      test_bad_ch();
      test_collision();
`ifdef LED_BLINKER_PWM_EN
      test_pwm();
`endif
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
